// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: PHY transfer descriptor, splitter state and request attributes.
package hyperbus_pkg;

  localparam int unsigned HyperBurstWidth = 16;

  typedef struct packed {
    logic [31:0]                address;
    logic [HyperBurstWidth-1:0] burst;
    logic                       write;
    logic                       address_space;
    logic                       burst_type;
  } hyper_tf_t;

  typedef enum logic {
    SplitIdle = 1'b0,
    SplitEmit = 1'b1
  } split_state_e;

  typedef struct packed {
    logic write;
    logic address_space;
    logic burst_type;
  } split_req_t;

  localparam hyper_tf_t HyperTfReset = '{
    address:       '0,
    burst:         '0,
    write:         1'b0,
    address_space: 1'b0,
    burst_type:    1'b1
  };

endpackage

// File: rtl/hyperbus_tf_splitter.sv
// Splits a word-length request into PHY transfers bounded by max burst and chip end.
// Optional HYPERBUS_SPLIT_ERR_EN: flag and abort chunks beyond the last chip.
module hyperbus_tf_splitter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips      = 2,
  parameter int unsigned ChipAddrWidth = 23,
  parameter int unsigned BurstWidth    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [BurstWidth-1:0] cfg_max_burst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  input  logic [BurstWidth-1:0] req_len_i,
  input  logic                  req_write_i,
  input  logic                  req_addr_space_i,
  input  logic                  req_burst_type_i,
  output logic                  trans_valid_o,
  input  logic                  trans_ready_i,
  output hyper_tf_t             trans_o,
  output logic [NumChips-1:0]   trans_cs_o,
  output logic                  trans_last_o,
  output logic                  err_o
);

  localparam int unsigned ChipIdxW = (NumChips > 1) ? $clog2(NumChips) : 1;
  localparam logic [32:0] ChipSize = 33'd1 << ChipAddrWidth;
  localparam logic [32:0] ChipMask = ChipSize - 33'd1;
  localparam logic [ChipIdxW-1:0] ChipIdxMask = ChipIdxW'(NumChips - 1);

  split_state_e          state_q;
  split_req_t            attr_q;
  logic [32:0]           addr_q;
  logic [BurstWidth-1:0] rem_q;
  logic [BurstWidth-1:0] burst_q;
  logic                  valid_q;
  logic                  last_q;
  logic [NumChips-1:0]   cs_q;
  hyper_tf_t             trans_q;

  split_req_t            src_attr;
  logic [32:0]           src_addr;
  logic [BurstWidth-1:0] src_rem;
  logic [32:0]           words_end;
  logic [32:0]           lim;
  logic [BurstWidth-1:0] burst_c;
  logic [ChipIdxW-1:0]   chip_idx;
  logic [NumChips-1:0]   cs_c;
  logic                  last_c;
  logic                  load_c;
  logic                  range_err_c;

  // The chunk source is the fresh request in Idle, or the post-handshake remainder in Emit.
  always_comb begin
    src_attr  = attr_q;
    src_addr  = addr_q + (33'(burst_q) << 1);
    src_rem   = rem_q - burst_q;
    load_c    = 1'b0;
    if (state_q == SplitIdle) begin
      src_attr = '{write: req_write_i, address_space: req_addr_space_i,
                   burst_type: req_burst_type_i};
      src_addr = {1'b0, req_addr_i & ~32'h1};
      src_rem  = req_len_i;
      load_c   = req_valid_i && (req_len_i != '0);
    end else begin
      load_c   = trans_ready_i && !last_q;
    end

    words_end = (ChipSize - (src_addr & ChipMask)) >> 1;
    lim       = 33'(src_rem);
    if ((cfg_max_burst_i != '0) && (33'(cfg_max_burst_i) < lim)) lim = 33'(cfg_max_burst_i);
    if (words_end < lim) lim = words_end;
    burst_c   = lim[BurstWidth-1:0];
    last_c    = (burst_c == src_rem);

    chip_idx  = src_addr[ChipAddrWidth +: ChipIdxW] & ChipIdxMask;
    cs_c      = NumChips'(1) << chip_idx;
  end

`ifdef HYPERBUS_SPLIT_ERR_EN
  logic err_q;

  assign range_err_c = (src_addr >> ChipAddrWidth) >= 33'(NumChips);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= load_c && range_err_c;
  end

  assign err_o = err_q;
`else
  assign range_err_c = 1'b0;
  assign err_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SplitIdle;
      attr_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      burst_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cs_q    <= '0;
      trans_q <= HyperTfReset;
    end else begin
      if (state_q == SplitIdle && req_valid_i) attr_q <= src_attr;
      if (load_c) begin
        if (range_err_c) begin
          state_q <= SplitIdle;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end else begin
          state_q               <= SplitEmit;
          valid_q               <= 1'b1;
          addr_q                <= src_addr;
          rem_q                 <= src_rem;
          burst_q               <= burst_c;
          last_q                <= last_c;
          cs_q                  <= cs_c;
          trans_q.address       <= 32'(src_addr >> 1);
          trans_q.burst         <= HyperBurstWidth'(burst_c);
          trans_q.write         <= src_attr.write;
          trans_q.address_space <= src_attr.address_space;
          trans_q.burst_type    <= src_attr.burst_type;
        end
      end else if (state_q == SplitEmit && trans_ready_i) begin
        state_q <= SplitIdle;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign req_ready_o   = (state_q == SplitIdle);
  assign trans_valid_o = valid_q;
  assign trans_o       = trans_q;
  assign trans_cs_o    = cs_q;
  assign trans_last_o  = last_q;

endmodule

// File: tb/tb_hyperbus_tf_splitter.sv
// Scoreboard bench for hyperbus_tf_splitter; honours HYPERBUS_SPLIT_ERR_EN for the range case.
module tb_hyperbus_tf_splitter;
  import hyperbus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_max = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic        req_write = 1'b0;
  logic        req_aspace = 1'b0;
  logic        req_btype = 1'b1;
  logic        trans_valid;
  logic        trans_ready = 1'b1;
  hyper_tf_t   trans;
  logic [1:0]  trans_cs;
  logic        trans_last;
  logic        err;

  hyperbus_tf_splitter dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cfg_max_burst_i  (cfg_max),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_addr_i       (req_addr),
    .req_len_i        (req_len),
    .req_write_i      (req_write),
    .req_addr_space_i (req_aspace),
    .req_burst_type_i (req_btype),
    .trans_valid_o    (trans_valid),
    .trans_ready_i    (trans_ready),
    .trans_o          (trans),
    .trans_cs_o       (trans_cs),
    .trans_last_o     (trans_last),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] burst;
    logic [1:0]  cs;
    logic        last;
    logic        wr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [15:0] b, input logic [1:0] cs,
                      input logic last, input logic wr);
    exp_t e;
    e.addr = a; e.burst = b; e.cs = cs; e.last = last; e.wr = wr;
    exp_q.push_back(e);
  endtask

  // Monitor: every negedge with valid&ready precedes a handshake edge.
  always @(negedge clk) begin
    if (rst_n && trans_valid && trans_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", {32'b0, trans.address}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("xfer_addr",  64'(trans.address), 64'(e.addr));
        chk("xfer_burst", 64'(trans.burst),   64'(e.burst));
        chk("xfer_cs",    64'(trans_cs),      64'(e.cs));
        chk("xfer_last",  64'(trans_last),    64'(e.last));
        chk("xfer_write", 64'(trans.write),   64'(e.wr));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [15:0] len, input logic [15:0] mx,
                      input logic wr);
    bit done;
    @(posedge clk); #1;
    cfg_max = mx; req_addr = a; req_len = len; req_write = wr; req_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) chk("req_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && req_ready && !trans_valid;
    end
    if (!done) chk({name, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hyper_tf_t stall_exp;

    // Reset values, then ready in the first cycle after release.
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(trans_valid), 64'd0);
    chk("rst_last",  64'(trans_last),  64'd0);
    chk("rst_err",   64'(err),         64'd0);
    chk("rst_cs",    64'(trans_cs),    64'd0);
    chk("rst_trans", 64'(trans),       64'(HyperTfReset));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 64'(req_ready), 64'd1);

    // Single transfer, 1-cycle latency.
    push(32'h0, 16'd8, 2'b01, 1'b1, 1'b1);
    send(32'h0, 16'd8, 16'd0, 1'b1);
    @(negedge clk);
    chk("t1_latency_valid", 64'(trans_valid), 64'd1);
    wait_idle("t1");

    // Max-burst split, back-to-back.
    push(32'h00, 16'd16, 2'b01, 1'b0, 1'b0);
    push(32'h10, 16'd16, 2'b01, 1'b0, 1'b0);
    push(32'h20, 16'd8,  2'b01, 1'b1, 1'b0);
    send(32'h0, 16'd40, 16'd16, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_b2b_valid", 64'(trans_valid), 64'd1);
    end
    @(negedge clk);
    chk("t2_valid_drop", 64'(trans_valid), 64'd0);
    wait_idle("t2");

    // Chip boundary crossing.
    push(32'h3F_FFFC, 16'd4, 2'b01, 1'b0, 1'b0);
    push(32'h40_0000, 16'd4, 2'b10, 1'b1, 1'b0);
    send(32'h7F_FFF8, 16'd8, 16'd0, 1'b0);
    wait_idle("t3");

    // PHY stall: outputs must hold.
    @(posedge clk); #1 trans_ready = 1'b0;
    push(32'h80, 16'd4, 2'b01, 1'b1, 1'b0);
    send(32'h100, 16'd4, 16'd0, 1'b0);
    stall_exp = '{address: 32'h80, burst: 16'd4, write: 1'b0, address_space: 1'b0,
                  burst_type: 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stall_trans",  64'(trans),       64'(stall_exp));
      chk("t4_stall_cs",     64'(trans_cs),    64'd1);
      chk("t4_stall_last",   64'(trans_last),  64'd1);
      chk("t4_stall_valid",  64'(trans_valid), 64'd1);
      chk("t4_stall_rready", 64'(req_ready),   64'd0);
    end
    @(posedge clk); #1 trans_ready = 1'b1;
    wait_idle("t4");

    // Max burst changed after the first chunk is computed.
    push(32'h100, 16'd4, 2'b01, 1'b0, 1'b0);
    push(32'h104, 16'd8, 2'b01, 1'b1, 1'b0);
    send(32'h200, 16'd12, 16'd4, 1'b0);
    cfg_max = 16'd8;
    wait_idle("t5");

    // Zero-length request.
    send(32'h40, 16'd0, 16'd0, 1'b0);
    @(negedge clk);
    chk("t6_len0_valid", 64'(trans_valid), 64'd0);
    chk("t6_len0_ready", 64'(req_ready),   64'd1);

    // Address beyond the last chip.
`ifdef HYPERBUS_SPLIT_ERR_EN
    send(32'h0100_0000, 16'd4, 16'd0, 1'b0);
    @(negedge clk);
    chk("t7_err_pulse", 64'(err),         64'd1);
    chk("t7_err_valid", 64'(trans_valid), 64'd0);
    chk("t7_err_ready", 64'(req_ready),   64'd1);
    @(negedge clk);
    chk("t7_err_one_cycle", 64'(err), 64'd0);
`else
    push(32'h80_0000, 16'd4, 2'b01, 1'b1, 1'b0);
    send(32'h0100_0000, 16'd4, 16'd0, 1'b0);
    @(negedge clk);
    chk("t7_err_low", 64'(err), 64'd0);
`endif
    wait_idle("t7");

    // Reset mid-request after chunk 1 of 3.
    @(posedge clk); #1 trans_ready = 1'b0;
    push(32'h800, 16'd8, 2'b01, 1'b0, 1'b0);
    send(32'h1000, 16'd24, 16'd8, 1'b0);
    @(posedge clk); #1 trans_ready = 1'b1;
    @(posedge clk); #1 trans_ready = 1'b0;
    @(negedge clk);
    chk("t8_chunk2_valid", 64'(trans_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("t8_rst_valid", 64'(trans_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t8_release_ready", 64'(req_ready),   64'd1);
    chk("t8_release_valid", 64'(trans_valid), 64'd0);
    @(posedge clk); #1 trans_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t8_no_residual", 64'(trans_valid), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
